// File: rtl/terminal_dump.sv
// terminal_dump: streams one full screen of terminal text memory out over a
// valid/ready byte interface, row by row, column by column.
// Non-printable bytes (below 0x20 or above 0x7E) are replaced with '.'.
// Optional feature macro TERMINAL_DUMP_NEWLINE_EN: when defined, each row is
// followed by CR (0x0D) and LF (0x0A); when undefined, rows run together.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; busy low
// ADDR    | textAddress presented for the current row/column
// CAPTURE | memory returns the byte; it is sanitised and registered
// SEND    | out_valid high with the character, waiting for out_ready
// CR      | out_valid high with 0x0D (newline build only)
// LF      | out_valid high with 0x0A (newline build only)
// FINISH  | one-cycle done pulse, then back to IDLE
module terminal_dump #(
   parameter int unsigned COLUMNS   = 80,
   parameter int unsigned ROWS      = 30,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [11:0] textAddress,
   input  logic [7:0]  textReadData,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      CAPTURE,
      SEND,
`ifdef TERMINAL_DUMP_NEWLINE_EN
      CR,
      LF,
`endif
      FINISH
   } state_t;

   localparam logic [11:0] COL_LAST = 12'(COLUMNS - 1);
   localparam logic [11:0] ROW_LAST = 12'(ROWS - 1);

   // Screen must fit the 12-bit text address space.
   generate
      if ((ROWS * COLUMNS > 4096) || (ROWS == 0) || (COLUMNS == 0)) begin : g_bad_geometry
         $error("terminal_dump: ROWS*COLUMNS must be between 1 and 4096");
      end
   endgenerate

   state_t      state_q, state_d;
   logic [11:0] row_q, row_d;
   logic [11:0] col_q, col_d;
   logic [11:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        row_end;

   // Linear text address; wraps modulo 4096 so a high BASE_ADDR rolls over to 0.
   function automatic logic [11:0] addr_of(input logic [11:0] r, input logic [11:0] c);
      return 12'(BASE_ADDR + 32'(r) * COLUMNS + 32'(c));
   endfunction

   function automatic logic [7:0] printable(input logic [7:0] b);
      return ((b < 8'h20) || (b > 8'h7E)) ? 8'h2E : b;
   endfunction

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      addr_d  = addr_q;
      data_d  = data_q;
      row_end = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               row_d   = '0;
               col_d   = '0;
               state_d = ADDR;
            end
         end
         ADDR:    state_d = CAPTURE;
         CAPTURE: begin
            data_d  = printable(textReadData);
            state_d = SEND;
         end
         SEND: begin
            if (out_ready) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
`ifdef TERMINAL_DUMP_NEWLINE_EN
                  state_d = CR;
                  data_d  = 8'h0D;
`else
                  row_end = 1'b1;
`endif
               end else begin
                  col_d   = col_q + 12'd1;
                  state_d = ADDR;
               end
            end
         end
`ifdef TERMINAL_DUMP_NEWLINE_EN
         CR: begin
            if (out_ready) begin
               state_d = LF;
               data_d  = 8'h0A;
            end
         end
         LF: begin
            if (out_ready) row_end = 1'b1;
         end
`endif
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (row_end) begin
         if (row_q == ROW_LAST) begin
            state_d = FINISH;
         end else begin
            row_d   = row_q + 12'd1;
            state_d = ADDR;
         end
      end

      // Address only changes on entry to ADDR, so it is stable through CAPTURE
      // and while a byte is stalled in SEND.
      if (state_d == ADDR) addr_d = addr_of(row_d, col_d);

      busy_d  = (state_d != IDLE);
      done_d  = (state_d == FINISH);
`ifdef TERMINAL_DUMP_NEWLINE_EN
      valid_d = (state_d == SEND) || (state_d == CR) || (state_d == LF);
`else
      valid_d = (state_d == SEND);
`endif
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign textAddress = addr_q;
   assign out_data    = data_q;
   assign out_valid   = valid_q;

endmodule

// File: tb/tb_terminal_dump.sv
// Bench for terminal_dump: a 4x2 screen instance for the main scenarios and a
// 4x1 instance at BASE_ADDR 0xFFE for address wrap-around.
module tb_terminal_dump;

   typedef struct packed {
      logic [7:0]  data;
      logic        chk_addr;
      logic [11:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, start, out_ready, start2, ready2;
   logic        busy, done, out_valid, busy2, done2, valid2;
   logic [11:0] addr1, addr2;
   logic [7:0]  rd1, rd2, out_data, data2;
   logic [7:0]  mem [0:4095];

   exp_t exp_q[$];
   exp_t e2;
   int   total = 0;
   int   bad   = 0;
   int   n2, d2;

   always #5 clk = ~clk;

   always @(posedge clk) rd1 <= mem[addr1];
   always @(posedge clk) rd2 <= mem[addr2];

   terminal_dump #(.COLUMNS(4), .ROWS(2), .BASE_ADDR(0)) u_dut (
      .clock(clk), .reset(rst_n), .start(start), .busy(busy), .done(done),
      .textAddress(addr1), .textReadData(rd1), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   terminal_dump #(.COLUMNS(4), .ROWS(1), .BASE_ADDR(12'hFFE)) u_dut_wrap (
      .clock(clk), .reset(rst_n), .start(start2), .busy(busy2), .done(done2),
      .textAddress(addr2), .textReadData(rd2), .out_data(data2),
      .out_valid(valid2), .out_ready(ready2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] printable(input logic [7:0] b);
      return ((b < 8'h20) || (b > 8'h7E)) ? 8'h2E : b;
   endfunction

   task automatic push_screen(input int base, input int cols, input int rows);
      exp_t e;
      int   a;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            a          = (base + r * cols + c) % 4096;
            e.data     = printable(mem[a]);
            e.chk_addr = 1'b1;
            e.addr     = 12'(a);
            exp_q.push_back(e);
         end
`ifdef TERMINAL_DUMP_NEWLINE_EN
         e = '0; e.data = 8'h0D; exp_q.push_back(e);
         e = '0; e.data = 8'h0A; exp_q.push_back(e);
`endif
      end
   endtask

   task automatic load_text(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                            input logic [7:0] b6, input logic [7:0] b7);
      mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
      mem[4] = b4; mem[5] = b5; mem[6] = b6; mem[7] = b7;
   endtask

   // Drives one dump on the main instance from a negedge. Handshakes are
   // judged at negedge: valid & ready there means a transfer on the next posedge.
   task automatic run_dump(input string tag, input int stall_idx, input int restart_cyc,
                           input int abort_cyc);
      int          cyc, idx, stall, done_cyc, ndone, first_lat, nbytes, exp_total;
      bit          aborted, any_done, any_valid;
      logic [11:0] held_addr;
      exp_t        e;
      exp_total = exp_q.size();
      cyc = 0; idx = 0; stall = 0; done_cyc = -1; ndone = 0; first_lat = -1; nbytes = 0;
      aborted = 1'b0; held_addr = '0;
      start = 1'b1;
      out_ready = 1'b1;
      while (cyc < 400 && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_cyc);
         if (cyc == abort_cyc) begin
            rst_n = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check({tag, "_abort_busy"}, busy, 0);
            check({tag, "_abort_valid"}, out_valid, 0);
            check({tag, "_abort_addr"}, addr1, 0);
            rst_n = 1'b1;
            any_done = 1'b0;
            any_valid = 1'b0;
            repeat (5) begin
               @(negedge clk);
               any_done  |= done;
               any_valid |= out_valid;
            end
            check({tag, "_abort_no_done"}, any_done, 0);
            check({tag, "_abort_no_output"}, any_valid, 0);
            exp_q.delete();
            aborted = 1'b1;
            break;
         end
         if (done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) check({tag, "_busy_after_done"}, busy, 0);
         if (out_valid && first_lat < 0) first_lat = cyc;
         if (out_valid && idx == stall_idx && stall < 20) begin
            if (stall == 0) held_addr = addr1;
            out_ready = 1'b0;
            stall++;
            if (stall == 20) begin
               check({tag, "_stall_valid"}, out_valid, 1);
               check({tag, "_stall_data"}, out_data, 8'h42);
               check({tag, "_stall_addr"}, addr1, held_addr);
            end
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check({tag, "_data"}, out_data, e.data);
               if (e.chk_addr) check({tag, "_addr"}, addr1, e.addr);
            end
            nbytes++;
            idx++;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      if (!aborted) begin
         check({tag, "_done_seen"}, done_cyc >= 0, 1);
         check({tag, "_done_pulses"}, ndone, 1);
         check({tag, "_byte_count"}, nbytes, exp_total);
         check({tag, "_first_latency"}, first_lat, 3);
         check({tag, "_idle_valid"}, out_valid, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      out_ready = 1'b1;
      start2 = 1'b0;
      ready2 = 1'b1;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      load_text("A", "B", "C", "D", "E", "F", "G", "H");
      mem[12'hFFE] = "Y";
      mem[12'hFFF] = "Z";

      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_valid", out_valid, 0);
      check("reset_data", out_data, 8'h00);
      check("reset_addr", addr1, 12'h000);
      check("reset_busy_wrap", busy2, 0);
      rst_n = 1'b1;
      @(negedge clk);

      push_screen(0, 4, 2);
      run_dump("plain", -1, -1, -1);

      push_screen(0, 4, 2);
      run_dump("stall", 1, -1, -1);

      push_screen(0, 4, 2);
      run_dump("restart", -1, 5, -1);

      load_text(8'h07, 8'h80, 8'h7E, 8'h41, 8'h1F, 8'h20, 8'h7F, 8'h7A);
      push_screen(0, 4, 2);
      run_dump("sanitize", -1, -1, -1);

      load_text("A", "B", "C", "D", "E", "F", "G", "H");
      push_screen(0, 4, 2);
      run_dump("abort", -1, -1, 6);

      push_screen(0, 4, 2);
      run_dump("after_abort", -1, -1, -1);

      push_screen(12'hFFE, 4, 1);
      n2 = 0;
      d2 = 0;
      start2 = 1'b1;
      for (int k = 0; k < 60 && d2 == 0; k++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (done2) d2 = 1;
         if (valid2) begin
            if (exp_q.size() > 0) begin
               e2 = exp_q.pop_front();
               check("wrap_data", data2, e2.data);
               if (e2.chk_addr) check("wrap_addr", addr2, e2.addr);
            end
            n2++;
         end
      end
      check("wrap_done_seen", d2, 1);
`ifdef TERMINAL_DUMP_NEWLINE_EN
      check("wrap_byte_count", n2, 6);
`else
      check("wrap_byte_count", n2, 4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/terminal_dump.md
TERMINAL_DUMP -- requirements
Module: terminal_dump

Interface
REQ-001 SHALL provide parameter COLUMNS, default 80: characters per text row.
REQ-002 SHALL provide parameter ROWS, default 30: text rows per screen.
REQ-003 SHALL provide parameter BASE_ADDR, default 0: text address of row 0, column 0.
REQ-004 SHALL provide port clock, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL provide port reset, input, 1: reset, synchronous and active-low.
REQ-006 SHALL provide port start, input, 1: request one full-screen dump.
REQ-007 SHALL provide port busy, output, 1: high while a dump is in progress.
REQ-008 SHALL provide port done, output, 1: one-cycle pulse when a dump completes.
REQ-009 SHALL provide port textAddress, output, 12: terminal text-memory read address.
REQ-010 SHALL provide port textReadData, input, 8: character at the address presented on the previous clock.
REQ-011 SHALL provide port out_data, output, 8: outgoing byte.
REQ-012 SHALL provide port out_valid, output, 1: out_data holds a byte to transfer.
REQ-013 SHALL provide port out_ready, input, 1: sink accepts the byte this cycle.

Function
REQ-014 SHALL read text memory with a fixed 1-cycle latency: address presented in cycle N, data captured at the end of cycle N+1.
REQ-015 SHALL implement FSM states IDLE, ADDR, CAPTURE, SEND, CR, LF, FINISH.
REQ-016 SHALL transition IDLE->ADDR on start=1 and clear the row and column counters to 0; start SHALL be ignored in every other state.
REQ-017 SHALL drive textAddress = BASE_ADDR + row*COLUMNS + col, truncated to 12 bits, in ADDR and hold it through CAPTURE.
REQ-018 SHALL go ADDR->CAPTURE->SEND, registering textReadData in CAPTURE.
REQ-019 SHALL substitute 0x2E for any captured byte below 0x20 or above 0x7E; all other bytes pass unchanged.
REQ-020 SHALL assert out_valid in SEND, CR and LF only, holding out_data stable until out_valid and out_ready are both 1 on the same cycle.
REQ-021 SHALL, on a SEND handshake, increment col; if col was COLUMNS-1, set col to 0 and go to CR (macro defined) or to the row-end step (macro undefined); otherwise go to ADDR.
REQ-022 SHALL emit 0x0D in CR and 0x0A in LF, advancing CR->LF->row-end only on a handshake.
REQ-023 SHALL, at row-end, increment row and go to ADDR, or go to FINISH if row was ROWS-1.
REQ-024 SHALL pulse done for exactly one cycle in FINISH and then return to IDLE.
REQ-025 SHALL hold busy=1 in every state except IDLE.
REQ-026 SHALL require ROWS*COLUMNS <= 4096, checked at elaboration.
REQ-027 SHALL tolerate out_ready held low indefinitely: no byte lost, duplicated or reordered, and textAddress unchanged.
REQ-028 SHALL emit exactly ROWS*COLUMNS character bytes per dump, plus 2*ROWS bytes when the macro is defined.

Reset
REQ-029 SHALL, when reset=0 at a clock edge, enter IDLE, clear the counters, and drive busy=0, done=0, out_valid=0, out_data=0x00, textAddress=0.
REQ-030 SHALL abort a dump when reset is asserted mid-operation, with no done pulse and no further output.

Configuration
REQ-031 SHALL, with macro TERMINAL_DUMP_NEWLINE_EN defined, append 0x0D 0x0A after each row's last character.
REQ-032 SHALL, with TERMINAL_DUMP_NEWLINE_EN undefined, omit the CR and LF states and emit no line separators.

Verification
REQ-033 SHALL verify: COLUMNS=4, ROWS=2, memory "ABCD","EFGH", out_ready=1, macro defined -> "ABCD\r\nEFGH\r\n" (12 bytes), then a single done pulse.
REQ-034 SHALL verify: same stimulus with the macro undefined -> "ABCDEFGH" (8 bytes), with the first byte appearing 3 cycles after start.
REQ-035 SHALL verify: memory byte 0x07 and memory byte 0x80 -> each emitted as 0x2E; 0x7E -> emitted as 0x7E.
REQ-036 SHALL verify: out_ready held low 20 cycles on the 2nd byte -> out_data stays 0x42 and out_valid stays 1, then the stream resumes intact.
REQ-037 SHALL verify: start pulsed mid-dump -> ignored, byte count unchanged; reset=0 mid-dump -> busy=0 next cycle and no done pulse.
REQ-038 SHALL verify: BASE_ADDR=0xFFE, COLUMNS=4, ROWS=1 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
